// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential restoring divider.
//   div_state_t     : controller state encoding (IDLE / RUN / DONE)
//   DEF_DIVIDEND_W  : default dividend / quotient width
//   DEF_DIVISOR_W   : default divisor / remainder width
package div_pkg;

    localparam int DEF_DIVIDEND_W = 7;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
//   rem_in   : partial remainder before the step (always < divisor)
//   bit_in   : next dividend bit, MSB first
//   divisor  : divisor operand
//   rem_out  : partial remainder after shift-in and conditional subtract
//   q_bit    : quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    // One bit wider than the partial remainder so the shifted value is never
    // truncated before the compare.
    logic [DIVISOR_W+1:0] trial;
    logic [DIVISOR_W:0]   diff;

    always_comb begin
        trial = {rem_in, bit_in};
        q_bit = (trial >= {2'b00, divisor});
        // When q_bit is set, trial < 2*divisor, so the difference fits.
        diff  = trial[DIVISOR_W:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : trial[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle unsigned restoring divider, one bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request strobe, accepted in IDLE or DONE only
//   dividend   : unsigned dividend (DIVIDEND_W bits), latched on acceptance
//   divisor    : unsigned divisor (DIVISOR_W bits), latched on acceptance
//   busy       : high while the iteration runs
//   done       : one-cycle pulse marking a fresh result
//   quotient   : unsigned quotient (all ones on divide-by-zero)
//   remainder  : unsigned remainder (zero on divide-by-zero)
//   dbz        : divide-by-zero flag for the current result
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    div_state_t state, state_nxt;

    logic                  accept;
    logic                  zero_div;
    logic                  last_step;
    logic [CNT_W-1:0]      cnt;
    // Dividend bits shift out at the top while quotient bits shift in at
    // the bottom, so one register serves both.
    logic [DIVIDEND_W-1:0] work_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVISOR_W:0]    rem_nxt;
    logic                  q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (work_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        accept    = start && (state != ST_RUN);
        zero_div  = (divisor == '0);
        last_step = (cnt == CNT_W'(DIVIDEND_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = zero_div ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = zero_div ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient  <= '1;
                remainder <= '0;
                dbz       <= 1'b1;
            end else begin
                work_q <= dividend;
                dvs_q  <= divisor;
                rem_q  <= '0;
                cnt    <= '0;
                dbz    <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            work_q <= {work_q[DIVIDEND_W-2:0], q_bit};
            rem_q  <= rem_nxt;
            cnt    <= cnt + CNT_W'(1);
            // Results reach the outputs only on the final step.
            if (last_step) begin
                quotient  <= {work_q[DIVIDEND_W-2:0], q_bit};
                remainder <= rem_nxt[DIVISOR_W-1:0];
            end
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 7, SHALL be the dividend and quotient width (matches the 3x4 product width).
REQ-002 Parameter DIVISOR_W, default 4, SHALL be the divisor and remainder width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be the request strobe, sampled on the rising edge.
REQ-006 dividend  input  DIVIDEND_W  SHALL be the unsigned dividend, sampled when start is accepted.
REQ-007 divisor  input  DIVISOR_W  SHALL be the unsigned divisor, sampled when start is accepted.
REQ-008 busy  output  1  SHALL be high while an iteration is in progress.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-010 quotient  output  DIVIDEND_W  SHALL be the unsigned quotient.
REQ-011 remainder  output  DIVISOR_W  SHALL be the unsigned remainder.
REQ-012 dbz  output  1  SHALL flag divide-by-zero for the current result.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; busy = (state == RUN).
REQ-014 start SHALL be accepted only in IDLE or DONE; in RUN it SHALL be ignored with no effect.
REQ-015 On acceptance with divisor != 0 at edge k: operands SHALL be latched, partial remainder cleared, bit counter cleared, state -> RUN, dbz cleared.
REQ-016 RUN SHALL perform one restoring step per edge, MSB first: r = {r, next dividend bit}; if r >= divisor then r = r - divisor and quotient bit = 1, else quotient bit = 0.
REQ-017 Partial remainder SHALL be DIVISOR_W+1 bits wide so the compare/subtract never overflows.
REQ-018 Exactly DIVIDEND_W steps SHALL execute; the final step at edge k+DIVIDEND_W SHALL update quotient/remainder, assert done, and set state -> DONE.
REQ-019 done SHALL be high for exactly the one cycle following edge k+DIVIDEND_W (7 cycles for defaults); state returns to IDLE on the next edge unless start is accepted.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-021 quotient, remainder and dbz SHALL hold their values until the next accepted start; they SHALL not change during a rejected start.
REQ-022 On acceptance with divisor == 0 at edge k: no RUN phase; at edge k state -> DONE, done = 1, dbz = 1, quotient = all ones, remainder = 0.
REQ-023 start accepted in DONE (back-to-back) SHALL behave identically to acceptance in IDLE; done SHALL still deassert after one cycle.
REQ-024 Intermediate quotient/remainder values SHALL NOT be visible on the outputs during RUN; outputs keep the previous result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy 0, done 0, dbz 0, quotient 0, remainder 0, counter 0, regardless of clock.
REQ-026 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow reset release without a new start.
REQ-027 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package div_pkg SHALL hold the state enum typedef and the default DIVIDEND_W/DIVISOR_W constants.
REQ-029 One combinational sub-module div_step SHALL implement a single restoring step (shift-in, compare, conditional subtract, quotient bit); seq_divider instantiates it once and iterates.
REQ-030 Bit counter SHALL be clog2(DIVIDEND_W+1) bits; no multipliers or division operators in RTL.

Verification
REQ-031 dividend 100, divisor 7 -> busy 7 cycles, then done pulse with quotient 14, remainder 2, dbz 0.
REQ-032 dividend 127, divisor 1 -> quotient 127, remainder 0; dividend 5, divisor 9 -> quotient 0, remainder 5.
REQ-033 dividend 91, divisor 0 -> done one cycle after start, dbz 1, quotient 127, remainder 0.
REQ-034 rst_n pulsed low at step 3 of 100/7 -> all outputs 0 immediately, no done afterwards; a fresh 91/13 start -> quotient 7, remainder 0.
REQ-035 start held high through RUN of 100/7 with dividend changed to 50 -> result still 14 r 2; start still high in DONE -> new 50/7 accepted, quotient 7, remainder 1.
REQ-036 Exhaustive sweep of all 7-bit x nonzero 4-bit operands -> quotient*divisor + remainder == dividend and remainder < divisor on every done.
